// File: rtl/vs_spi_pkg.sv
// Shared types and constants for the VS-series decoder SPI transmitter.
// Holds the FSM state encoding, the SCI write opcode, frame size and mode codes.
package vs_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_DREQ,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD
   } state_t;

   localparam logic [7:0]  SCI_WRITE_OP = 8'h02;
   localparam int unsigned FRAME_BITS   = 32;

   localparam logic MODE_SCI = 1'b0;
   localparam logic MODE_SDI = 1'b1;

   // SCI frames carry opcode, address and a 16-bit value; SDI frames are raw data.
   function automatic logic [31:0] frame_word(input logic        mode,
                                              input logic [7:0]  addr,
                                              input logic [31:0] data);
      return (mode == MODE_SDI) ? data : {SCI_WRITE_OP, addr, data[15:0]};
   endfunction

endpackage

// File: rtl/vs_spi_tx.sv
// SPI mode-0 frame transmitter for a VS-series audio decoder (SCI writes and SDI data).
// Waits for DREQ, then shifts one 32-bit frame MSB first under the matching chip select.
module vs_spi_tx
   import vs_spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic        i_mode,
   input  logic [7:0]  i_addr,
   input  logic [31:0] i_data,
   input  logic        i_DREQ,
   output logic        o_XCS,
   output logic        o_XDCS,
   output logic        o_SCK,
   output logic        o_SI,
   output logic        o_busy,
   output logic        o_done
);

   localparam int unsigned      CNT_W    = $clog2(CLK_DIV) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [5:0]       BIT_LAST = 6'(FRAME_BITS - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [5:0]        bit_q, bit_d;
   logic [31:0]       sh_q, sh_d;
   logic              mode_q, mode_d;
   logic              xcs_q, xcs_d;
   logic              xdcs_q, xdcs_d;
   logic              sck_q, sck_d;
   logic              si_q, si_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              phase_end;

   assign phase_end = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      mode_d  = mode_q;
      xcs_d   = xcs_q;
      xdcs_d  = xdcs_q;
      sck_d   = sck_q;
      si_d    = si_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               sh_d    = frame_word(i_mode, i_addr, i_data);
               mode_d  = i_mode;
               busy_d  = 1'b1;
               state_d = ST_WAIT_DREQ;
            end
         end
         ST_WAIT_DREQ: begin
            if (i_DREQ) begin
               if (mode_q == MODE_SDI) xdcs_d = 1'b0;
               else                    xcs_d  = 1'b0;
               si_d    = sh_q[31];
               cnt_d   = '0;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (phase_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               sck_d   = 1'b1;
               state_d = ST_SHIFT;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_SHIFT: begin
            if (!phase_end) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d = '0;
               // Falling edge advances SI; the end of a low phase closes one bit.
               if (sck_q) begin
                  sck_d = 1'b0;
                  sh_d  = {sh_q[30:0], 1'b0};
                  si_d  = sh_q[30];
               end else if (bit_q == BIT_LAST) begin
                  state_d = ST_HOLD;
               end else begin
                  bit_d = bit_q + 6'd1;
                  sck_d = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (phase_end) begin
               cnt_d   = '0;
               xcs_d   = 1'b1;
               xdcs_d  = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         mode_q  <= MODE_SCI;
         xcs_q   <= 1'b1;
         xdcs_q  <= 1'b1;
         sck_q   <= 1'b0;
         si_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         mode_q  <= mode_d;
         xcs_q   <= xcs_d;
         xdcs_q  <= xdcs_d;
         sck_q   <= sck_d;
         si_q    <= si_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign o_XCS  = xcs_q;
   assign o_XDCS = xdcs_q;
   assign o_SCK  = sck_q;
   assign o_SI   = si_q;
   assign o_busy = busy_q;
   assign o_done = done_q;

endmodule

// File: doc/vs_spi_tx.md
VS_SPI_TX -- requirements
Module: vs_spi_tx

Interface
REQ-001 Parameter CLK_DIV, default 4, SCK half-period in clk cycles; legal range 2..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 i_start  input  1  one-cycle request to send a frame; accepted only when o_busy=0.
REQ-005 i_mode  input  1  frame type: 0 = SCI register write, 1 = SDI data.
REQ-006 i_addr  input  8  SCI register address; ignored when i_mode=1.
REQ-007 i_data  input  32  payload: SCI uses [15:0]; SDI sends all 32 bits (4 bytes).
REQ-008 i_DREQ  input  1  decoder data-request; high means the decoder can accept a frame.
REQ-009 o_XCS  output  1  SCI chip select, active low.
REQ-010 o_XDCS  output  1  SDI chip select, active low.
REQ-011 o_SCK  output  1  serial clock, idle low.
REQ-012 o_SI  output  1  serial data, MSB first.
REQ-013 o_busy  output  1  high from the cycle after an accepted i_start until the frame completes.
REQ-014 o_done  output  1  one-cycle pulse on frame completion.

Function
REQ-015 States SHALL be IDLE, WAIT_DREQ, SETUP, SHIFT, HOLD.
REQ-016 IDLE: on i_start=1, latch the shift register as {8'h02, i_addr, i_data[15:0]} (mode 0) or i_data[31:0] (mode 1), latch the mode, and go to WAIT_DREQ; o_busy=1 from the next cycle.
REQ-017 WAIT_DREQ: remain while i_DREQ=0; when i_DREQ=1, drive the selected CS low (o_XCS for mode 0, o_XDCS for mode 1), drive o_SI with bit 31, and go to SETUP.
REQ-018 SETUP: last CLK_DIV cycles with o_SCK=0, then go to SHIFT.
REQ-019 SHIFT: send 32 bits; each bit is o_SCK high for CLK_DIV cycles, then low for CLK_DIV cycles; o_SI changes only on the SCK falling transition (SPI mode 0).
REQ-020 After the 32nd falling SCK transition, go to HOLD with o_SCK=0 and the CS still low; HOLD lasts CLK_DIV cycles.
REQ-021 HOLD exit: raise the CS, set o_busy=0, pulse o_done=1 for exactly that cycle, and return to IDLE.
REQ-022 Latency with i_DREQ already high at start: o_busy is high for 1 + CLK_DIV*66 cycles; exactly 32 rising SCK edges occur per frame.
REQ-023 i_start while o_busy=1 SHALL be ignored; no queuing.
REQ-024 i_DREQ is sampled only in WAIT_DREQ; a drop mid-frame SHALL NOT stall or abort the frame.
REQ-025 o_XCS and o_XDCS SHALL never be low at the same time.
REQ-026 Input changes after acceptance SHALL NOT affect the frame in progress.
REQ-027 The half-period counter SHALL be $clog2(CLK_DIV)+1 bits wide and the bit counter 6 bits; counters SHALL never wrap mid-phase.

Reset
REQ-028 While rst_n=0 at a clock edge: state=IDLE, o_XCS=1, o_XDCS=1, o_SCK=0, o_SI=0, o_busy=0, o_done=0, and all counters and the shift register cleared.
REQ-029 Reset mid-frame SHALL abort the frame immediately, with no o_done pulse; the first i_start after rst_n=1 SHALL be accepted normally.

Structure
REQ-030 Package vs_spi_pkg SHALL hold the state enum, SCI_WRITE_OP=8'h02, FRAME_BITS=32, and the mode encodings.
REQ-031 No sub-module; the SCK divider and bit counter are inline, single always block for the state/datapath.

Verification
REQ-032 CLK_DIV=2, i_DREQ=1, mode 0, i_addr=8'h0B, i_data=32'h0000FCFC -> o_XCS low, o_XDCS high, 32 SCK rising edges, SI sampled at rising edges = 32'h020BFCFC, o_done 133 cycles after start.
REQ-033 Mode 1, i_data=32'hDEADBEEF, i_DREQ=0 for 10 cycles then 1 -> o_XDCS stays high until DREQ rises, then stream = 32'hDEADBEEF, o_XCS stays high throughout.
REQ-034 Second i_start issued 20 cycles into a frame -> ignored; exactly one o_done pulse and one frame.
REQ-035 i_DREQ dropped to 0 after 10 SCK edges -> frame completes unaltered with 32 edges.
REQ-036 rst_n=0 for one cycle mid-SHIFT -> next cycle all outputs at reset values, no o_done; a new frame then completes correctly.
